lcd_cmd_sequencer: RTL
======================

Name: lcd_cmd_sequencer

Overview:
Upstream feeder for the LCD controller block. It buffers host commands in a small FIFO and holds a 64-pixel image store written by the host. It issues each command to the LCD controller only while the controller is not busy, and it streams the 64-pixel image immediately after every LOAD command. It replaces the bench-driven command/datain handshake with synthesizable logic.

Parameters:
CMD_DEPTH, 8, command FIFO depth in entries (power of 2, minimum 2)
IMG_N, 64, pixels per image (8x8)
DW, 8, pixel width in bits

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high
host_cmd  in  3  command code to enqueue
host_cmd_valid  in  1  enqueue request; accepted when host_cmd_ready=1
host_cmd_ready  out  1  FIFO not full
img_we  in  1  image store write strobe; honoured only when img_wready=1
img_waddr  in  6  pixel index 0..63, raster order
img_wdata  in  DW  pixel value
img_wready  out  1  low while an image stream is in progress
lcd_busy  in  1  busy flag from the LCD controller
lcd_cmd  out  3  command to the controller; 0 when not issuing
lcd_cmd_valid  out  1  one-cycle issue pulse
lcd_datain  out  DW  pixel stream to the controller; 0 outside a stream
seq_idle  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset is synchronous: the FIFO is emptied and the FSM goes to IDLE.
  - Reset values: lcd_cmd=0, lcd_cmd_valid=0, lcd_datain=0, host_cmd_ready=1, img_wready=1, seq_idle=1.
  - Image store contents are not cleared.
  - Reset mid-stream aborts the stream at once; lcd_datain is 0 from the next cycle.
- Command FIFO:
  - Enqueue when host_cmd_valid && host_cmd_ready.
  - Enqueue and dequeue in the same cycle are both allowed when the FIFO is full.
  - No overflow is possible. A dequeue from an empty FIFO never occurs.
  - Read/write pointers are log2(CMD_DEPTH)+1 bits, so wrap-around is handled with the extra bit.
- Image store:
  - 64xDW register file; a write lands at the clock edge.
  - img_we while img_wready=0 is dropped.
  - Writes outside a stream are visible to the next stream.
- FSM states: IDLE, ISSUE, STREAM, GUARD, WAIT.
  - IDLE: if the FIFO is non-empty and lcd_busy=0, go to ISSUE.
  - ISSUE (one cycle):
    - Drive lcd_cmd_valid=1 and lcd_cmd=FIFO head, then pop.
    - If cmd==LOAD, go to STREAM with pix_cnt=0 and img_wready=0; otherwise go to GUARD.
  - STREAM:
    - The cycle after ISSUE carries pixel 0; pixel k appears on cycle issue+1+k, k=0..63.
    - After pixel 63, lcd_datain returns to 0, img_wready returns to 1, and the FSM goes to GUARD.
    - lcd_busy is ignored during STREAM.
  - GUARD: a fixed 2 cycles in which lcd_busy is ignored, so the controller has time to assert busy. Then go to WAIT.
  - WAIT: stay while lcd_busy=1. On lcd_busy=0, go to ISSUE if the FIFO is non-empty, else IDLE.
- Minimum spacing between two non-LOAD issues is 4 cycles (ISSUE + GUARD x2 + WAIT).
- Codes 6 and 7 are forwarded unchanged and treated as non-LOAD.
- seq_idle = (state==IDLE) && FIFO empty.

Decomposition:
- Package lcd_pkg holds:
  - cmd_t, 3-bit enum: CMD_REFLASH=0, CMD_LOAD=1, CMD_SHR=2, CMD_SHL=3, CMD_SHU=4, CMD_SHD=5.
  - Constants IMG_N=64, GUARD_CYC=2.
  - FSM state enum.
- One sub-module, sync_fifo (parameterised width/depth), instantiated for the command queue.

Test Plan:
- Load and stream: write pixels 0..63 with value=index; enqueue LOAD with lcd_busy=0 -> lcd_cmd_valid at cycle t with lcd_cmd=1; lcd_datain=0x00..0x3F on t+1..t+64; lcd_datain=0 at t+65.
- Busy gating: enqueue SHR and SHL; hold lcd_busy=1 from 1 cycle after the first issue for 10 cycles -> second lcd_cmd_valid (lcd_cmd=3) occurs exactly 1 cycle after lcd_busy falls, never earlier.
- FIFO full: hold lcd_busy=1 and enqueue 8 commands -> host_cmd_ready=0 after the 8th; a 9th is not accepted; release busy -> all 8 issued in order, seq_idle=1 at the end.
- Write lockout: assert img_we to addr 5 with data 0xAA during STREAM -> img_wready=0 and the write is dropped; the next LOAD streams the original value 0x05 at pixel 5.
- Reset mid-stream: assert reset at pixel 20 -> next cycle lcd_datain=0, lcd_cmd_valid=0, FIFO empty; a new LOAD then restarts at pixel 0.
- Simultaneous push/pop when full: FIFO at 8 entries, push in the ISSUE cycle -> count stays 8 and command order is preserved.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command sequencer.
package lcd_pkg;

  // Command codes understood by the LCD controller; 6 and 7 pass through as non-LOAD.
  typedef enum logic [2:0] {
    CMD_REFLASH = 3'd0,
    CMD_LOAD    = 3'd1,
    CMD_SHR     = 3'd2,
    CMD_SHL     = 3'd3,
    CMD_SHU     = 3'd4,
    CMD_SHD     = 3'd5
  } cmd_t;

  localparam int unsigned IMG_N     = 64;
  // Cycles after an issue or stream during which lcd_busy is not yet trusted.
  localparam int unsigned GUARD_CYC = 2;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StStream,
    StGuard,
    StWait
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push into a full FIFO is taken
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  // Status flags, handshake qualification and pointer advance.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    rdata_o  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Feeds queued host commands to the LCD controller, gating on lcd_busy, and
// streams the image store right after every LOAD.
module lcd_cmd_sequencer #(
  parameter int unsigned CMD_DEPTH = 8,
  parameter int unsigned IMG_N     = 64,
  parameter int unsigned DW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    host_cmd,
  input  logic          host_cmd_valid,
  output logic          host_cmd_ready,
  input  logic          img_we,
  input  logic [5:0]    img_waddr,
  input  logic [DW-1:0] img_wdata,
  output logic          img_wready,
  input  logic          lcd_busy,
  output logic [2:0]    lcd_cmd,
  output logic          lcd_cmd_valid,
  output logic [DW-1:0] lcd_datain,
  output logic          seq_idle
);

  import lcd_pkg::*;

  localparam int unsigned PW = $clog2(IMG_N);
  localparam logic [PW-1:0] LastPix = PW'(IMG_N - 1);

  seq_state_e    state_q, state_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [1:0]    guard_cnt_q, guard_cnt_d;
  logic [2:0]    lcd_cmd_q, lcd_cmd_d;
  logic          lcd_cmd_valid_q, lcd_cmd_valid_d;
  logic [DW-1:0] lcd_datain_q, lcd_datain_d;
  logic          img_wready_q, img_wready_d;
  logic [DW-1:0] img_q [IMG_N];

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2:0] fifo_rdata;

  sync_fifo #(
    .Width(3),
    .Depth(CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i  (clk),
    .rst_i  (reset),
    .push_i (fifo_push),
    .wdata_i(host_cmd),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // The head leaves the FIFO in the issue cycle, which frees a slot for a same-cycle push.
  always_comb begin
    fifo_pop       = lcd_cmd_valid_q;
    host_cmd_ready = !fifo_full || fifo_pop;
    fifo_push      = host_cmd_valid && host_cmd_ready;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d         = state_q;
    pix_cnt_d       = pix_cnt_q;
    guard_cnt_d     = guard_cnt_q;
    lcd_cmd_d       = '0;
    lcd_cmd_valid_d = 1'b0;
    lcd_datain_d    = '0;
    img_wready_d    = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !lcd_busy) begin
          state_d         = StIssue;
          lcd_cmd_valid_d = 1'b1;
          lcd_cmd_d       = fifo_rdata;
        end
      end
      StIssue: begin
        if (cmd_t'(lcd_cmd_q) == CMD_LOAD) begin
          state_d      = StStream;
          pix_cnt_d    = '0;
          lcd_datain_d = img_q[0];
          img_wready_d = 1'b0;
        end else begin
          state_d     = StGuard;
          guard_cnt_d = '0;
        end
      end
      StStream: begin
        if (pix_cnt_q == LastPix) begin
          state_d     = StGuard;
          guard_cnt_d = '0;
        end else begin
          pix_cnt_d    = pix_cnt_q + PW'(1);
          lcd_datain_d = img_q[pix_cnt_d];
          img_wready_d = 1'b0;
        end
      end
      StGuard: begin
        if (guard_cnt_q == 2'(GUARD_CYC - 1)) begin
          state_d = StWait;
        end else begin
          guard_cnt_d = guard_cnt_q + 2'd1;
        end
      end
      StWait: begin
        if (!lcd_busy) begin
          if (!fifo_empty) begin
            state_d         = StIssue;
            lcd_cmd_valid_d = 1'b1;
            lcd_cmd_d       = fifo_rdata;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      pix_cnt_q       <= '0;
      guard_cnt_q     <= '0;
      lcd_cmd_q       <= '0;
      lcd_cmd_valid_q <= 1'b0;
      lcd_datain_q    <= '0;
      img_wready_q    <= 1'b1;
    end else begin
      state_q         <= state_d;
      pix_cnt_q       <= pix_cnt_d;
      guard_cnt_q     <= guard_cnt_d;
      lcd_cmd_q       <= lcd_cmd_d;
      lcd_cmd_valid_q <= lcd_cmd_valid_d;
      lcd_datain_q    <= lcd_datain_d;
      img_wready_q    <= img_wready_d;
    end
  end

  // Image store; survives reset, locked while a stream is reading it.
  always_ff @(posedge clk) begin
    if (img_we && img_wready_q) begin
      img_q[img_waddr] <= img_wdata;
    end
  end

  // Output drive.
  always_comb begin
    lcd_cmd       = lcd_cmd_q;
    lcd_cmd_valid = lcd_cmd_valid_q;
    lcd_datain    = lcd_datain_q;
    img_wready    = img_wready_q;
    seq_idle      = (state_q == StIdle) && fifo_empty;
  end

endmodule
